// File: rtl/bubble_sort_pkg.sv
// Shared types and sizing helpers for the bubble sort engine.
// Optional early exit is selected by BUBBLE_SORT_EARLY_EXIT_EN.
package bubble_sort_pkg;

   typedef enum logic [1:0] {
      LOAD,
      SORT,
      UNLOAD
   } sort_state_t;

   function automatic int idx_width(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/compare_swap.sv
// Combinational compare-and-swap cell: orders one pair ascending.
// Equal words pass straight through, keeping the sort stable.
module compare_swap #(
   parameter int k = 32
) (
   input  logic [k-1:0] lo_in,
   input  logic [k-1:0] hi_in,
   output logic [k-1:0] lo_out,
   output logic [k-1:0] hi_out,
   output logic         swap
);

   assign swap   = lo_in > hi_in;
   assign lo_out = swap ? hi_in : lo_in;
   assign hi_out = swap ? lo_in : hi_in;

endmodule

// File: rtl/bubble_sort_engine.sv
// Load N words, bubble sort them one compare per clock, stream them out.
// Define BUBBLE_SORT_EARLY_EXIT_EN to stop after a pass with no swaps.
import bubble_sort_pkg::*;

module bubble_sort_engine #(
   parameter int k = 32,
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [k-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [k-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   localparam int W = idx_width(N);
   localparam logic [W-1:0] LAST_IDX  = W'(N - 1);
   localparam logic [W-1:0] LAST_PASS = W'(N - 2);

   sort_state_t state, state_n;

   logic [W-1:0] idx, idx_n;
   logic [W-1:0] pass, pass_n;
   logic [W-1:0] j, j_n;
   logic [W-1:0] j_hi;
   logic [W-1:0] last_j;
   logic [k-1:0] a [N];
   logic [k-1:0] lo_out;
   logic [k-1:0] hi_out;
   logic         swap;
   logic         load_fire;
   logic         unload_fire;
   logic         pass_end;
   logic         sort_done;

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
   logic swapped, swapped_n;
`endif

   assign j_hi   = j + 1'b1;
   assign last_j = LAST_PASS - pass;

   compare_swap #(
      .k(k)
   ) u_cs (
      .lo_in (a[j]),
      .hi_in (a[j_hi]),
      .lo_out(lo_out),
      .hi_out(hi_out),
      .swap  (swap)
   );

   assign in_ready    = (state == LOAD);
   assign out_valid   = (state == UNLOAD);
   assign busy        = (state == SORT);
   assign out_data    = out_valid ? a[idx] : '0;
   assign load_fire   = in_valid && in_ready;
   assign unload_fire = out_valid && out_ready;
   assign pass_end    = (j == last_j);

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
   assign sort_done = pass_end &&
                      ((pass == LAST_PASS) || !(swapped || swap));
`else
   assign sort_done = pass_end && (pass == LAST_PASS);
`endif

   always_comb begin
      state_n = state;
      idx_n   = idx;
      pass_n  = pass;
      j_n     = j;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      swapped_n = swapped;
`endif
      unique case (state)
         LOAD: begin
            if (load_fire) begin
               if (idx == LAST_IDX) begin
                  state_n = SORT;
                  idx_n   = '0;
                  pass_n  = '0;
                  j_n     = '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                  swapped_n = 1'b0;
`endif
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         SORT: begin
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            swapped_n = swapped | swap;
`endif
            if (pass_end) begin
               j_n    = '0;
               pass_n = pass + 1'b1;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
               swapped_n = 1'b0;
`endif
               if (sort_done) begin
                  state_n = UNLOAD;
                  pass_n  = '0;
               end
            end else begin
               j_n = j + 1'b1;
            end
         end
         UNLOAD: begin
            if (unload_fire) begin
               if (idx == LAST_IDX) begin
                  state_n = LOAD;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: begin
            state_n = LOAD;
            idx_n   = '0;
            pass_n  = '0;
            j_n     = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= LOAD;
         idx   <= '0;
         pass  <= '0;
         j     <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         pass  <= pass_n;
         j     <= j_n;
      end
   end

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         swapped <= 1'b0;
      end else begin
         swapped <= swapped_n;
      end
   end
`endif

   // Loads and swaps are mutually exclusive by state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            a[i] <= '0;
         end
      end else if (load_fire) begin
         a[idx] <= in_data;
      end else if (busy && swap) begin
         a[j]    <= lo_out;
         a[j_hi] <= hi_out;
      end
   end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine against a queue-sort model.
// Build with BUBBLE_SORT_EARLY_EXIT_EN to check the early-exit timing.
module tb_bubble_sort_engine;

   localparam int K    = 32;
   localparam int NW   = 8;
   localparam int FULL = NW * (NW - 1) / 2;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
   localparam int SORTED_CYC = NW - 1;
`else
   localparam int SORTED_CYC = FULL;
`endif

   typedef logic [K-1:0] word_t;
   typedef word_t wq_t[$];

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [K-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [K-1:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         busy;

   int total = 0;
   int bad   = 0;

   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   always #5 clock = ~clock;

   bubble_sort_engine #(
      .k(K),
      .N(NW)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy)
   );

   function automatic wq_t model(input word_t w [NW]);
      wq_t q;
      q = {};
      for (int i = 0; i < NW; i++) q.push_back(w[i]);
      q.sort();
      return q;
   endfunction

   // Drives one job end to end and reports what it observed.
   task automatic run_job(
      input  word_t w [NW],
      input  bit    gaps,
      input  int    rmode,
      output int    busy_cyc,
      output wq_t   outq,
      output int    unstable,
      output int    early_drop,
      output bit    tmo
   );
      int    g;
      int    c;
      bit    held;
      bit    r;
      word_t hv;
      outq = {};
      busy_cyc = 0;
      unstable = 0;
      early_drop = 0;
      tmo = 1'b0;
      held = 1'b0;
      hv = '0;
      for (int i = 0; i < NW; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clock);
            #1;
         end
         in_data  = w[i];
         in_valid = 1'b1;
         @(posedge clock);
         #1;
         in_valid = 1'b0;
         if (i < NW - 1 && !in_ready) early_drop++;
         if (i == NW - 1 && in_ready) early_drop++;
      end
      g = 0;
      while (busy && g < 500) begin
         busy_cyc++;
         @(posedge clock);
         #1;
         g++;
      end
      if (g >= 500) tmo = 1'b1;
      c = 0;
      while (outq.size() < NW && c < 500) begin
         if (rmode == 0) r = 1'b1;
         else if (rmode == 1) r = pat[c % 6];
         else r = 1'($urandom_range(0, 1));
         out_ready = r;
         if (out_valid) begin
            if (held && out_data !== hv) unstable++;
            if (r) begin
               outq.push_back(out_data);
               held = 1'b0;
            end else begin
               held = 1'b1;
               hv   = out_data;
            end
         end
         @(posedge clock);
         #1;
         c++;
      end
      out_ready = 1'b0;
      if (c >= 500) tmo = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0) begin
         $display("FAIL reset_hold got rdy/ov/busy=%b%b%b data=%0h exp 100/0",
                  in_ready, out_valid, busy, out_data);
         bad++;
      end
      reset = 1'b1;
      @(posedge clock);
      #1;
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0) begin
         $display("FAIL reset_release got rdy/ov/busy=%b%b%b data=%0h exp 100/0",
                  in_ready, out_valid, busy, out_data);
         bad++;
      end
   endtask

   task automatic test_reverse;
      word_t w [NW];
      wq_t   q, e;
      int    bc, un, ed;
      bit    tmo;
      for (int i = 0; i < NW; i++) w[i] = word_t'(NW - i);
      run_job(w, 1'b0, 0, bc, q, un, ed, tmo);
      e = model(w);
      total++;
      if (tmo || q.size() != NW || q != e) begin
         $display("FAIL reverse_data got=%p exp=%p", q, e);
         bad++;
      end
      total++;
      if (bc != FULL) begin
         $display("FAIL reverse_busy got=%0d exp=%0d", bc, FULL);
         bad++;
      end
   endtask

   task automatic test_sorted;
      word_t w [NW];
      wq_t   q, e;
      int    bc, un, ed;
      bit    tmo;
      for (int i = 0; i < NW; i++) w[i] = word_t'(i + 1);
      run_job(w, 1'b0, 0, bc, q, un, ed, tmo);
      e = model(w);
      total++;
      if (tmo || q != e) begin
         $display("FAIL sorted_data got=%p exp=%p", q, e);
         bad++;
      end
      total++;
      if (bc != SORTED_CYC) begin
         $display("FAIL sorted_busy got=%0d exp=%0d", bc, SORTED_CYC);
         bad++;
      end
   endtask

   task automatic test_dups;
      word_t w [NW];
      wq_t   q, e;
      int    bc, un, ed;
      bit    tmo;
      w = '{32'd5, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd1};
      run_job(w, 1'b0, 0, bc, q, un, ed, tmo);
      e = {32'd0, 32'd0, 32'd1, 32'd3, 32'd3, 32'd5, 32'd5, 32'hFFFF_FFFF};
      total++;
      if (tmo || q != e) begin
         $display("FAIL dups_data got=%p exp=%p", q, e);
         bad++;
      end
`ifndef BUBBLE_SORT_EARLY_EXIT_EN
      total++;
      if (bc != FULL) begin
         $display("FAIL dups_busy got=%0d exp=%0d", bc, FULL);
         bad++;
      end
`endif
   endtask

   task automatic test_backpressure;
      word_t w [NW];
      wq_t   q, e;
      int    bc, un, ed;
      bit    tmo;
      for (int i = 0; i < NW; i++) w[i] = $urandom;
      run_job(w, 1'b0, 1, bc, q, un, ed, tmo);
      e = model(w);
      total++;
      if (tmo || q != e) begin
         $display("FAIL bp_data got=%p exp=%p", q, e);
         bad++;
      end
      total++;
      if (un != 0) begin
         $display("FAIL bp_stable got=%0d changes exp=0", un);
         bad++;
      end
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL bp_return got ov=%b rdy=%b exp ov=0 rdy=1",
                  out_valid, in_ready);
         bad++;
      end
   endtask

   task automatic test_load_gaps;
      word_t w [NW];
      wq_t   q, e;
      int    bc, un, ed;
      bit    tmo;
      for (int i = 0; i < NW; i++) w[i] = $urandom_range(0, 20);
      run_job(w, 1'b1, 0, bc, q, un, ed, tmo);
      e = model(w);
      total++;
      if (tmo || q != e) begin
         $display("FAIL gaps_data got=%p exp=%p", q, e);
         bad++;
      end
      total++;
      if (ed != 0) begin
         $display("FAIL gaps_ready got=%0d bad in_ready samples exp=0", ed);
         bad++;
      end
   endtask

   task automatic test_reset_mid_sort;
      word_t w [NW];
      wq_t   q, e;
      int    bc, un, ed;
      bit    tmo;
      for (int i = 0; i < NW; i++) begin
         in_data  = $urandom;
         in_valid = 1'b1;
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      total++;
      if (busy !== 1'b1) begin
         $display("FAIL abort_in_sort got busy=%b exp=1", busy);
         bad++;
      end
      reset = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0) begin
         $display("FAIL abort_async got rdy/ov/busy=%b%b%b data=%0h exp 100/0",
                  in_ready, out_valid, busy, out_data);
         bad++;
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      w[0] = 32'd2;
      w[1] = 32'd1;
      for (int i = 2; i < NW; i++) w[i] = $urandom_range(3, 1000);
      run_job(w, 1'b0, 0, bc, q, un, ed, tmo);
      e = model(w);
      total++;
      if (tmo || q != e) begin
         $display("FAIL abort_fresh got=%p exp=%p", q, e);
         bad++;
      end
   endtask

   task automatic test_back_to_back;
      word_t w [NW];
      wq_t   q, e;
      int    bc, un, ed;
      bit    tmo;
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < NW; i++) begin
            w[i] = (n % 2 == 0) ? $urandom : $urandom_range(0, 3);
         end
         run_job(w, 1'b0, 2, bc, q, un, ed, tmo);
         e = model(w);
         total++;
         if (tmo || q != e || un != 0) begin
            $display("FAIL b2b_job%0d got=%p exp=%p unstable=%0d", n, q, e, un);
            bad++;
         end
      end
   endtask

   initial begin
      test_reset;
      test_reverse;
      test_sorted;
      test_dups;
      test_backpressure;
      test_load_gaps;
      test_reset_mid_sort;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bubble_sort_engine.md
Name: bubble_sort_engine

Overview:
- Self-contained sorting stage that consumes the word-wide storage/mux datapath style used across the design.
- Accepts a burst of N words over a valid/ready stream and holds them in an internal N-entry register array.
- Sorts the array ascending (unsigned) with one compare-and-swap per clock, then streams the sorted words out over a second valid/ready interface.
- Sits between the upstream word producer and the downstream consumer of sorted data.

Parameters:
- k, 32, data word width in bits (k >= 1).
- N, 8, number of words per sort job (N >= 2).

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- in_data  input  k  word to load.
- in_valid  input  1  in_data valid.
- in_ready  output  1  engine can accept a word (LOAD state).
- out_data  output  k  sorted word at current unload index.
- out_valid  output  1  out_data valid (UNLOAD state).
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high while in SORT state.

Behaviour:
- Reset (reset==0, asynchronous): state=LOAD, load/unload index=0, pass=0, j=0, array contents=0. During and after reset: in_ready=1, out_valid=0, busy=0, out_data=0.
- All outputs are decoded from registered state only: no combinational in-to-out path.
- LOAD:
  - A word is accepted when in_valid && in_ready; it is written to a[idx] and idx increments.
  - in_valid low stalls with no change.
  - Acceptance of word N-1 moves to SORT on the next edge: idx=0, pass=0, j=0, swapped=0.
- SORT:
  - Each cycle compares a[j] and a[j+1]. If a[j] > a[j+1] (strict, unsigned), the two entries swap at the clock edge and swapped=1.
  - Pass p covers j = 0 .. N-2-p. At the end of a pass: p++, j=0, swapped=0.
  - After the final compare of pass N-2, the engine moves to UNLOAD.
  - Total SORT cycles = N(N-1)/2, i.e. 28 for N=8.
  - in_ready=0, out_valid=0, busy=1. Inputs are ignored.
- UNLOAD:
  - out_valid=1 and out_data=a[idx].
  - On out_valid && out_ready, idx increments.
  - out_data holds stable while out_ready is low.
  - The handshake on idx N-1 returns to LOAD (in_ready=1 on the next cycle), with idx=0.
  - Array contents are retained; they are overwritten by the next load.
- Index/counter widths: $clog2(N) bits, with a minimum of 1. Comparison is a full k-bit unsigned compare. Equal values never swap, so the sort is stable.
- Reset asserted mid-LOAD, mid-SORT or mid-UNLOAD aborts the job and returns to the reset values at once. No partial output is produced.
- No overlap: a new load cannot begin until the last unload handshake completes.

Optional Feature:
- Macro: BUBBLE_SORT_EARLY_EXIT_EN.
- Defined: at the end of any pass with swapped==0, go directly to UNLOAD on the next edge.
  - An already-sorted input spends N-1 SORT cycles (7 for N=8).
  - Results are identical to the non-early-exit build.
- Undefined: exactly N(N-1)/2 SORT cycles regardless of data. The swapped flag is not implemented.

Decomposition:
- Package bubble_sort_pkg holds:
  - typedef enum logic [1:0] sort_state_t {LOAD, SORT, UNLOAD}.
  - Localparam helper for the index width, $clog2(N) with a minimum of 1.
- Sub-module compare_swap (parameter k): combinational block.
  - Inputs: lo_in, hi_in.
  - Outputs: lo_out, hi_out, swap.
  - Instantiated once in the engine, muxed onto a[j] and a[j+1].

Test Plan:
1. N=8: load 8,7,6,5,4,3,2,1 with in_valid held high → out 1..8 in order; busy high for exactly 28 cycles.
2. Load 1..8 already sorted → out 1..8; busy for 28 cycles without the macro, 7 cycles with BUBBLE_SORT_EARLY_EXIT_EN.
3. Load 5,3,5,0,0xFFFFFFFF,3,0,1 → out 0,0,1,3,3,5,5,0xFFFFFFFF, confirming unsigned compare and correct duplicate handling.
4. Backpressure during unload with out_ready pattern 1,0,0,1,0,1,... → out_data stable across low cycles; exactly 8 handshakes, no drops or duplicates.
5. in_valid gaps during load (valid on alternate cycles) → all 8 words captured; in_ready drops only after the 8th acceptance.
6. Assert reset 10 cycles into SORT → outputs at reset values in the same cycle (asynchronous); a fresh load of 2,1,... then sorts correctly with no residue from the aborted job.
